lfsr_stream_gen: RTL and testbench
==================================

# lfsr_stream_gen

Parametrised Fibonacci LFSR stream generator, the general successor to the fixed 20-bit trigger-gated counter. Width, feedback taps, reset state and shifts-per-advance are parameters. Adds zero-seed lockup protection, an advance counter with sticky wrap flag, and a registered state-match pulse. It sits in the trojan/test-infrastructure path, seeded from the 128-bit data bus and stepped by a trigger/enable.

## Interface
- WIDTH, 20: LFSR state width, 2..64.
- TAPS, 20'h08881: feedback mask. Bit i set means state[i] feeds the XOR. Default gives X^20+X^13+X^9+X^5+1.
- INIT, 20'h00001: reset state and zero-seed substitute. Must be nonzero.
- STEP, 1: single-bit shifts applied per advance, 1..WIDTH.
- SEED_W, 128: seed bus width, ≥ WIDTH.
- CNT_W, 16: advance counter width, 1..32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  synchronous seed load.
- seed  in  SEED_W  seed bus; only seed[WIDTH-1:0] is used.
- advance  in  1  step enable (trigger).
- match_val  in  WIDTH  compare value.
- lfsr  out  WIDTH  current state, registered.
- match  out  1  one-cycle pulse; the state just produced by an advance equals match_val.
- zero_seed  out  1  one-cycle pulse; a load was attempted with an all-zero seed.
- adv_count  out  CNT_W  advances since the last load or reset.
- count_wrap  out  1  sticky flag; adv_count has wrapped.

## Operation
- Single shift: fb = XOR over i of (state[i] & TAPS[i]); next = {fb, state[WIDTH-1:1]}. This is a right shift with feedback into the MSB.
- Advance: STEP single shifts are composed combinationally and applied in one cycle. No multi-cycle sequencing.
- Priority per cycle: load > advance > hold.
- Load:
  - lfsr <= seed[WIDTH-1:0], or INIT if that slice is all zero.
  - zero_seed <= (slice == 0).
  - adv_count <= 0; count_wrap <= 0; match <= 0.
- Advance (no load):
  - lfsr <= STEP-shifted state.
  - adv_count <= adv_count + 1, modulo 2^CNT_W.
  - If adv_count was all-ones, count_wrap <= 1. It stays set until the next load or reset.
  - match <= (shifted state == match_val).
- Idle: state, count and wrap hold; match <= 0; zero_seed <= 0.
- match is computed from the next state, so match and the matching lfsr value appear in the same cycle.
- A load that coincides with advance performs the load only; the counter is not incremented.
- Lockup: the all-zero state is never reachable. INIT is nonzero, zero seeds are replaced, and XOR feedback from a nonzero state never produces zero.
- match_val is sampled only in advance cycles. Changing it while idle has no effect on match.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Asynchronous reset (rst low) sets: lfsr = INIT, adv_count = 0, count_wrap = 0, match = 0, zero_seed = 0. These values hold while rst is low and take effect immediately, including mid-stream.
- Release: the first state update occurs on the first rising clk edge after rst is deasserted with load or advance high.
- Latency:
  - load → lfsr valid: 1 cycle.
  - advance → new lfsr, adv_count and match: 1 cycle.
- Throughput: one advance (STEP shifts) per cycle. Continuous advance is allowed.
- Pulses: zero_seed and match last exactly one cycle per event. Back-to-back events give back-to-back pulses.

## Test plan
- Default params, STEP=1: load seed=20'h00001, then 3 advances → lfsr 20'h80000, 20'h40000, 20'h20000; adv_count 1, 2, 3.
- STEP=4 build: load 20'h00001, 1 advance → lfsr = 20'h10000, adv_count = 1.
- Zero seed: load with seed=0 → lfsr = INIT (20'h00001), zero_seed high for exactly 1 cycle, adv_count = 0.
- Match, STEP=1: match_val = 20'h40000, load 20'h00001, 2 advances → match high only in the cycle lfsr = 20'h40000. Hold idle → match stays low.
- Wrap, CNT_W=4: load, then 16 advances → adv_count = 0 and count_wrap = 1. Further advances keep count_wrap = 1; a subsequent load clears it.
- Reset mid-stream and priority:
  - Assert rst low asynchronously between edges during advancing → lfsr = INIT and all counters/flags cleared immediately.
  - After release, a cycle with load = advance = 1 and seed = 20'h00ABC → lfsr = 20'h00ABC, adv_count = 0.

Source files
------------

// File: rtl/lfsr_stream_gen.sv
// Parametrised Fibonacci LFSR stream generator with zero-seed substitution,
// an advance counter with sticky wrap flag and a registered state-match pulse.
module lfsr_stream_gen #(
   parameter int                WIDTH  = 20,
   parameter logic [WIDTH-1:0]  TAPS   = 20'h08881,
   parameter logic [WIDTH-1:0]  INIT   = 20'h00001,
   parameter int                STEP   = 1,
   parameter int                SEED_W = 128,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [SEED_W-1:0] seed,
   input  logic              advance,
   input  logic [WIDTH-1:0]  match_val,
   output logic [WIDTH-1:0]  lfsr,
   output logic              match,
   output logic              zero_seed,
   output logic [CNT_W-1:0]  adv_count,
   output logic              count_wrap
);

   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0] adv_count_q, adv_count_d;
   logic             count_wrap_q, count_wrap_d;
   logic             match_q, match_d;
   logic             zero_seed_q, zero_seed_d;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH-1:0] seed_slice;
   logic             seed_zero;

   generate
      if (SEED_W > WIDTH) begin : g_seed_unused
         logic unused_seed_bits;
         assign unused_seed_bits = ^seed[SEED_W-1:WIDTH];
      end
   endgenerate

   // STEP single shifts are unrolled into one combinational advance
   always_comb begin
      stepped = lfsr_q;
      for (int i = 0; i < STEP; i++) begin
         stepped = {^(stepped & TAPS), stepped[WIDTH-1:1]};
      end
   end

   always_comb begin
      seed_slice   = seed[WIDTH-1:0];
      seed_zero    = (seed_slice == '0);
      lfsr_d       = lfsr_q;
      adv_count_d  = adv_count_q;
      count_wrap_d = count_wrap_q;
      match_d      = 1'b0;
      zero_seed_d  = 1'b0;
      if (load) begin
         lfsr_d       = seed_zero ? INIT : seed_slice;
         zero_seed_d  = seed_zero;
         adv_count_d  = '0;
         count_wrap_d = 1'b0;
      end else if (advance) begin
         lfsr_d       = stepped;
         adv_count_d  = adv_count_q + CNT_W'(1);
         count_wrap_d = count_wrap_q | (&adv_count_q);
         match_d      = (stepped == match_val);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q       <= INIT;
         adv_count_q  <= '0;
         count_wrap_q <= 1'b0;
         match_q      <= 1'b0;
         zero_seed_q  <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         adv_count_q  <= adv_count_d;
         count_wrap_q <= count_wrap_d;
         match_q      <= match_d;
         zero_seed_q  <= zero_seed_d;
      end
   end

   assign lfsr       = lfsr_q;
   assign adv_count  = adv_count_q;
   assign count_wrap = count_wrap_q;
   assign match      = match_q;
   assign zero_seed  = zero_seed_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench for lfsr_stream_gen: a default build (STEP=1, CNT_W=16)
// and a STEP=4 / CNT_W=4 build share stimulus and are compared to a model.
module tb_lfsr_stream_gen;

   localparam logic [19:0] TAPS = 20'h08881;
   localparam logic [19:0] INIT = 20'h00001;

   logic         clk;
   logic         rst;
   logic         load;
   logic [127:0] seed;
   logic         advance;
   logic [19:0]  match_val;

   logic [19:0]  a_lfsr, b_lfsr;
   logic         a_match, b_match, a_zs, b_zs, a_wrap, b_wrap;
   logic [15:0]  a_cnt;
   logic [3:0]   b_cnt;

   int checks;
   int errors;

   lfsr_stream_gen dut_a (
      .clk(clk), .rst(rst), .load(load), .seed(seed), .advance(advance),
      .match_val(match_val), .lfsr(a_lfsr), .match(a_match), .zero_seed(a_zs),
      .adv_count(a_cnt), .count_wrap(a_wrap)
   );

   lfsr_stream_gen #(.STEP(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .load(load), .seed(seed), .advance(advance),
      .match_val(match_val), .lfsr(b_lfsr), .match(b_match), .zero_seed(b_zs),
      .adv_count(b_cnt), .count_wrap(b_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state for each build: index 0 is dut_a, 1 is dut_b
   logic [19:0] m_lfsr [2];
   int          m_cnt  [2];
   logic        m_wrap [2];
   logic        m_match[2];
   logic        m_zs   [2];
   int          steps  [2];
   int          cmod   [2];

   typedef struct {
      logic         load;
      logic [127:0] seed;
      logic         adv;
      logic [19:0]  mv;
      logic [19:0]  exp_lfsr;
      int           exp_cnt;
      logic         exp_match;
      logic         exp_zs;
   } vec_t;

   vec_t vecs[10];

   // Feedback is the parity of the tapped bits, entering at the MSB
   function automatic logic [19:0] shift_n(input logic [19:0] s, input int n);
      logic [19:0] r;
      r = s;
      for (int k = 0; k < n; k++) begin
         r = (r >> 1) | (20'(($countones(r & TAPS) % 2)) << 19);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lfsr[k] = INIT; m_cnt[k] = 0; m_wrap[k] = 1'b0;
         m_match[k] = 1'b0; m_zs[k] = 1'b0;
      end
   endtask

   task automatic check_model();
      check("a_lfsr",  64'(a_lfsr),  64'(m_lfsr[0]));
      check("a_cnt",   64'(a_cnt),   64'(m_cnt[0]));
      check("a_wrap",  64'(a_wrap),  64'(m_wrap[0]));
      check("a_match", 64'(a_match), 64'(m_match[0]));
      check("a_zs",    64'(a_zs),    64'(m_zs[0]));
      check("b_lfsr",  64'(b_lfsr),  64'(m_lfsr[1]));
      check("b_cnt",   64'(b_cnt),   64'(m_cnt[1]));
      check("b_wrap",  64'(b_wrap),  64'(m_wrap[1]));
      check("b_match", 64'(b_match), 64'(m_match[1]));
      check("b_zs",    64'(b_zs),    64'(m_zs[1]));
   endtask

   task automatic applyStimulus(input logic ld, input logic [127:0] sd, input logic adv,
                                input logic [19:0] mv);
      logic [19:0] nxt;
      @(negedge clk);
      load = ld; seed = sd; advance = adv; match_val = mv;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (ld) begin
            m_lfsr[k]  = (sd[19:0] == 20'h0) ? INIT : sd[19:0];
            m_zs[k]    = (sd[19:0] == 20'h0);
            m_cnt[k]   = 0;
            m_wrap[k]  = 1'b0;
            m_match[k] = 1'b0;
         end else if (adv) begin
            nxt = shift_n(m_lfsr[k], steps[k]);
            if (m_cnt[k] == cmod[k] - 1) m_wrap[k] = 1'b1;
            m_cnt[k]   = (m_cnt[k] + 1) % cmod[k];
            m_match[k] = (nxt == mv);
            m_zs[k]    = 1'b0;
            m_lfsr[k]  = nxt;
         end else begin
            m_match[k] = 1'b0;
            m_zs[k]    = 1'b0;
         end
      end
      #1;
      check_model();
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      check({tag, "_lfsr"},  64'(a_lfsr),  64'(v.exp_lfsr));
      check({tag, "_cnt"},   64'(a_cnt),   64'(v.exp_cnt));
      check({tag, "_match"}, 64'(a_match), 64'(v.exp_match));
      check({tag, "_zs"},    64'(a_zs),    64'(v.exp_zs));
   endtask

   initial begin
      logic [127:0] rseed;
      logic [19:0]  rmv;
      checks = 0; errors = 0;
      steps[0] = 1; steps[1] = 4;
      cmod[0] = 65536; cmod[1] = 16;
      rst = 1'b0; load = 1'b0; seed = '0; advance = 1'b0; match_val = '0;

      vecs[0] = '{1'b1, 128'h00001,                 1'b0, 20'h0,     20'h00001, 0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 128'h0,                     1'b1, 20'h40000, 20'h80000, 1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 128'h0,                     1'b1, 20'h40000, 20'h40000, 2, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 128'h0,                     1'b1, 20'h40000, 20'h20000, 3, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 128'h0,                     1'b0, 20'h20000, 20'h20000, 3, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 128'h0,                     1'b0, 20'h0,     20'h00001, 0, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 128'h0,                     1'b0, 20'h0,     20'h00001, 0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, {108'hABCDEF, 20'h00000},   1'b0, 20'h0,     20'h00001, 0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 128'h0,                     1'b1, 20'h0,     20'h00001, 0, 1'b0, 1'b1};
      vecs[9] = '{1'b1, 128'h00ABC,                 1'b1, 20'h00ABC, 20'h00ABC, 0, 1'b0, 1'b0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].load, vecs[i].seed, vecs[i].adv, vecs[i].mv);
         checkOutput(i, vecs[i]);
      end

      // STEP=4 build: one advance from 00001 lands on 10000
      applyStimulus(1'b1, 128'h00001, 1'b0, 20'h0);
      applyStimulus(1'b0, 128'h0, 1'b1, 20'h0);
      check("step4_lfsr", 64'(b_lfsr), 64'h10000);
      check("step4_cnt",  64'(b_cnt),  64'd1);

      // Four-bit counter wraps after 16 advances; wrap is sticky until load
      applyStimulus(1'b1, 128'h00005, 1'b0, 20'h0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 128'h0, 1'b1, 20'h0);
      check("wrap_cnt",  64'(b_cnt),  64'd0);
      check("wrap_flag", 64'(b_wrap), 64'd1);
      check("nowrap_a",  64'(a_wrap), 64'd0);
      applyStimulus(1'b0, 128'h0, 1'b1, 20'h0);
      check("wrap_sticky", 64'(b_wrap), 64'd1);
      applyStimulus(1'b1, 128'h00007, 1'b0, 20'h0);
      check("wrap_clear", 64'(b_wrap), 64'd0);

      // Asynchronous reset between edges while advancing
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 128'h0, 1'b1, 20'h0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check("arst_lfsr", 64'(a_lfsr), 64'(INIT));
      check("arst_cnt",  64'(a_cnt),  64'd0);
      check("arst_bcnt", 64'(b_cnt),  64'd0);
      check("arst_blfsr", 64'(b_lfsr), 64'(INIT));
      @(posedge clk);
      #1;
      check_model();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 128'h00ABC, 1'b1, 20'h0);
      check("prio_lfsr", 64'(a_lfsr), 64'h00ABC);
      check("prio_cnt",  64'(a_cnt),  64'd0);

      // Randomised traffic against the model, steering match_val to hit matches
      for (int i = 0; i < 400; i++) begin
         rseed = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rseed[19:0] = 20'h0;
         if ($urandom_range(0, 2) == 0) rmv = shift_n(m_lfsr[0], 1);
         else if ($urandom_range(0, 3) == 0) rmv = shift_n(m_lfsr[1], 4);
         else rmv = 20'($urandom);
         applyStimulus($urandom_range(0, 9) == 0, rseed, $urandom_range(0, 9) < 7, rmv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
